norm_shift_pipe: RTL and testbench

- Streaming, parametrised magnitude normaliser for the NLP datapath (softmax/exp/log pre-scaling).
- Shifts an unsigned DATA_W-bit operand so its leading one lands at bit FRAC_W-1, giving an output in [2^(FRAC_W-1), 2^FRAC_W).
- Reports the signed shift applied.
- Two-stage pipeline with valid/ready on both sides: stage 1 is leading-one detect, stage 2 is barrel shift (plus optional rounding).

---
 rtl/norm_pkg.sv | 39 +++
 rtl/norm_lod.sv | 25 ++
 rtl/norm_shift_pipe.sv | 164 ++++++++++++++++
 tb/tb_norm_shift_pipe.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/norm_pkg.sv
// Shared types and helpers for the magnitude normaliser (norm_shift_pipe).
// Optional build macro: NORM_SHIFT_ROUND_EN (round-half-up on right shifts).
package norm_pkg;

  // Default configuration of the NLP datapath instance
  localparam int unsigned NORM_DATA_W = 16;
  localparam int unsigned NORM_FRAC_W = 8;

  // Ceiling log2, usable in constant expressions
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r = r + 1;
    end
    return r;
  endfunction

  // Signed shift width: index bits + sign + headroom for the rounding carry
  function automatic int unsigned sh_w(input int unsigned data_w);
    return clog2(data_w) + 2;
  endfunction

  localparam int unsigned NORM_SH_W = sh_w(NORM_DATA_W);

  // Two's complement shift amount: positive = right, negative = left
  typedef logic signed [NORM_SH_W-1:0] shift_t;

  // Normalised result for the default configuration
  typedef struct packed {
    logic [NORM_FRAC_W-1:0] mantissa;
    shift_t                 shift;
    logic                   zero;
  } norm_res_t;

endpackage

// File: rtl/norm_lod.sv
// Combinational leading-one detector: index of the most significant set bit
// and a flag for an all-zero operand.
module norm_lod
  import norm_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  localparam int unsigned IDX_W = clog2(DATA_W)
) (
  input  logic [DATA_W-1:0] data_i,
  output logic [IDX_W-1:0]  idx_c_o,
  output logic              zero_c_o
);

  // Scan upward so the highest set bit wins
  always_comb begin
    idx_c_o  = '0;
    zero_c_o = ~|data_i;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      if (data_i[i]) begin
        idx_c_o = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/norm_shift_pipe.sv
// Two-stage streaming magnitude normaliser: stage 1 finds the leading one,
// stage 2 shifts it to bit FRAC_W-1 and reports the signed shift applied.
// Optional build macro: NORM_SHIFT_ROUND_EN (round-half-up on right shifts).
module norm_shift_pipe
  import norm_pkg::*;
#(
  parameter int unsigned DATA_W     = NORM_DATA_W,
  parameter int unsigned FRAC_W     = NORM_FRAC_W,
  parameter int unsigned ALLOW_LEFT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [FRAC_W-1:0]        out_data,
  output logic [sh_w(DATA_W)-1:0]  out_shift,
  output logic                     out_zero
);

  localparam int unsigned IDX_W   = clog2(DATA_W);
  localparam int unsigned SH_W    = sh_w(DATA_W);
  localparam int unsigned MSB_POS = FRAC_W - 1;

  // Stage-2 payload, sized by this instance's parameters
  typedef struct packed {
    logic [FRAC_W-1:0] mant;
    logic [SH_W-1:0]   shift;
    logic              zero;
  } res_t;

  // Stage 1 registers
  logic              s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0] s1_data_q,  s1_data_d;
  logic [IDX_W-1:0]  s1_idx_q,   s1_idx_d;
  logic              s1_zero_q,  s1_zero_d;

  // Stage 2 registers
  logic              s2_valid_q, s2_valid_d;
  res_t              s2_res_q,   s2_res_d;

  logic              s1_adv;
  logic [IDX_W-1:0]  lod_idx;
  logic              lod_zero;

  res_t              norm_res;
  int                norm_s;
  logic [IDX_W-1:0]  r_amt;
  logic [IDX_W-1:0]  l_amt;
`ifdef NORM_SHIFT_ROUND_EN
  localparam int unsigned RND_W = FRAC_W + 1;
  logic              half_bit;
  logic [RND_W-1:0]  rnd_sum;
`endif

  norm_lod #(
    .DATA_W (DATA_W)
  ) u_lod (
    .data_i   (in_data),
    .idx_c_o  (lod_idx),
    .zero_c_o (lod_zero)
  );

  // Stage 1 may advance when stage 2 is empty or draining this cycle
  assign s1_adv   = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s1_adv;

  assign out_valid = s2_valid_q;
  assign out_data  = s2_res_q.mant;
  assign out_shift = s2_res_q.shift;
  assign out_zero  = s2_res_q.zero;

  // Stage 1 next state: capture operand and leading-one index on accept
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_idx_d   = s1_idx_q;
    s1_zero_d  = s1_zero_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_data_d = in_data;
        s1_idx_d  = lod_idx;
        s1_zero_d = lod_zero;
      end
    end
  end

  // Normalisation of the stage-1 operand (barrel shift plus optional rounding)
  always_comb begin
    norm_res = '0;
    norm_s   = int'(s1_idx_q) - int'(MSB_POS);
    r_amt    = '0;
    l_amt    = '0;
`ifdef NORM_SHIFT_ROUND_EN
    half_bit = 1'b0;
    rnd_sum  = '0;
`endif
    if (s1_zero_q) begin
      norm_res.zero = 1'b1;
    end else if (norm_s > 0) begin
      r_amt          = IDX_W'(norm_s);
      norm_res.mant  = FRAC_W'(s1_data_q >> r_amt);
      norm_res.shift = SH_W'(norm_s);
`ifdef NORM_SHIFT_ROUND_EN
      // Half bit is the most significant bit shifted out
      half_bit = 1'(s1_data_q >> (r_amt - IDX_W'(1)));
      rnd_sum  = RND_W'(norm_res.mant) + RND_W'(half_bit);
      if (rnd_sum[FRAC_W]) begin
        norm_res.mant  = FRAC_W'(1) << MSB_POS;
        norm_res.shift = SH_W'(norm_s + 1);
      end else begin
        norm_res.mant = rnd_sum[FRAC_W-1:0];
      end
`endif
    end else if (norm_s < 0) begin
      if (ALLOW_LEFT != 0) begin
        l_amt          = IDX_W'(-norm_s);
        norm_res.mant  = FRAC_W'(s1_data_q << l_amt);
        norm_res.shift = SH_W'(norm_s);
      end else begin
        // Right-shift-only mode: small operands pass through unshifted
        norm_res.mant  = s1_data_q[FRAC_W-1:0];
        norm_res.shift = '0;
      end
    end else begin
      norm_res.mant = s1_data_q[FRAC_W-1:0];
    end
  end

  // Stage 2 next state: load when stage 1 advances, hold under backpressure
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_res_d   = s2_res_q;
    if (s1_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_res_d = norm_res;
      end
    end
  end

  // Pipeline registers; reset discards everything in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_idx_q   <= '0;
      s1_zero_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_res_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_idx_q   <= s1_idx_d;
      s1_zero_q  <= s1_zero_d;
      s2_valid_q <= s2_valid_d;
      s2_res_q   <= s2_res_d;
    end
  end

endmodule

// File: tb/tb_norm_shift_pipe.sv
// Scoreboard bench for norm_shift_pipe (DATA_W=16, FRAC_W=8), one instance
// with left shifts enabled and one in right-shift-only mode sharing stimulus.
// Honours NORM_SHIFT_ROUND_EN in its reference model.
module tb_norm_shift_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_ready_nl;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_valid_nl;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [7:0]  out_data_nl;
  logic [5:0]  out_shift;
  logic [5:0]  out_shift_nl;
  logic        out_zero;
  logic        out_zero_nl;

  typedef struct {
    int data;
    int shift;
    int zero;
    int data_nl;
    int shift_nl;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_vec = 0;
  int   n_err = 0;
  bit   held = 0;
  int   h_data, h_shift, h_zero, h_data_nl;
  bit   bp_done;

  norm_shift_pipe #(.DATA_W(16), .FRAC_W(8), .ALLOW_LEFT(1)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_shift (out_shift),
    .out_zero  (out_zero)
  );

  norm_shift_pipe #(.DATA_W(16), .FRAC_W(8), .ALLOW_LEFT(0)) u_dut_nl (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready_nl),
    .in_data   (in_data),
    .out_valid (out_valid_nl),
    .out_ready (out_ready),
    .out_data  (out_data_nl),
    .out_shift (out_shift_nl),
    .out_zero  (out_zero_nl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
    end
  endtask

  // Reference: normalise by division/multiplication by powers of two
  function automatic exp_t model(input int d);
    exp_t r;
    int   p;
    int   s;
    int   m;
    r = '{default: 0};
    if (d == 0) begin
      r.zero = 1;
      return r;
    end
    p = 0;
    for (int i = 0; i < 16; i++) if (((d >> i) & 1) == 1) p = i;
    s = p - 7;
    if (s > 0) begin
      m = d / (1 << s);
`ifdef NORM_SHIFT_ROUND_EN
      if ((d % (1 << s)) * 2 >= (1 << s)) m = m + 1;
      if (m == 256) begin
        m = 128;
        s = s + 1;
      end
`endif
      r.data = m;    r.shift = s;
      r.data_nl = m; r.shift_nl = s;
    end else if (s < 0) begin
      r.data = d * (1 << (-s)); r.shift = s;
      r.data_nl = d;            r.shift_nl = 0;
    end else begin
      r.data = d;    r.shift = 0;
      r.data_nl = d; r.shift_nl = 0;
    end
    return r;
  endfunction

  // Monitor: handshakes are sampled mid-cycle; inputs only change just after posedge
  always @(negedge clk) begin
    if (rst) begin
      held = 0;
    end else begin
      if (held) begin
        chk("hold_valid",   int'(out_valid), 1);
        chk("hold_data",    int'(out_data), h_data);
        chk("hold_shift",   int'($signed(out_shift)), h_shift);
        chk("hold_zero",    int'(out_zero), h_zero);
        chk("hold_data_nl", int'(out_data_nl), h_data_nl);
      end
      held = out_valid && !out_ready;
      if (held) begin
        h_data    = int'(out_data);
        h_shift   = int'($signed(out_shift));
        h_zero    = int'(out_zero);
        h_data_nl = int'(out_data_nl);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("spurious_out", int'(out_valid), 0);
        end else begin
          e = sb.pop_front();
          chk("data",     int'(out_data), e.data);
          chk("shift",    int'($signed(out_shift)), e.shift);
          chk("zero",     int'(out_zero), e.zero);
          chk("valid_nl", int'(out_valid_nl), 1);
          chk("data_nl",  int'(out_data_nl), e.data_nl);
          chk("shift_nl", int'($signed(out_shift_nl)), e.shift_nl);
          chk("zero_nl",  int'(out_zero_nl), e.zero);
        end
      end
      if (in_valid && in_ready && in_ready_nl) sb.push_back(model(int'(in_data)));
    end
  end

  // Called just after a posedge; returns just after the posedge following acceptance
  task automatic send(input logic [15:0] d);
    int b;
    in_data  = d;
    in_valid = 1'b1;
    b = 0;
    @(negedge clk);
    while (!in_ready && b < 200) begin
      @(negedge clk);
      b++;
    end
    if (!in_ready) chk("send_timeout", int'(in_ready), 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int b;
    b = 0;
    while (sb.size() != 0 && b < 200) begin
      @(negedge clk);
      b++;
    end
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    bp_done   = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data",  int'(out_data), 0);
    chk("rst_out_shift", int'(out_shift), 0);
    chk("rst_out_zero",  int'(out_zero), 0);
    chk("rst_in_ready",  int'(in_ready), 1);

    // Latency: accept, then valid exactly two edges later
    @(posedge clk);
    #1 in_valid = 1'b1; in_data = 16'h1234;
    @(negedge clk);
    chk("lat_accept", int'(in_ready), 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("lat_c1_valid", int'(out_valid), 0);
    @(negedge clk);
    chk("lat_c2_valid", int'(out_valid), 1);
    @(posedge clk);
    #1;

    // Directed operands: left shift, passthrough, zero, extremes
    send(16'h0003);
    send(16'h00A5);
    send(16'h0000);
    send(16'hFFFF);
    send(16'h0001);
    send(16'h8000);
    send(16'h00FF);
    send(16'h007F);
    send(16'h0180);
    drain();

    // Backpressure: two operands fill the pipe, then in_ready drops
    out_ready = 1'b0;
    fork
      begin
        send(16'h0100);
        send(16'h0200);
        send(16'h0400);
        send(16'h0800);
      end
      begin
        repeat (3) @(negedge clk);
        chk("bp_in_ready", int'(in_ready), 0);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two operands in flight
    in_valid = 1'b1; in_data = 16'h0011;
    @(posedge clk);
    #1 in_data = 16'h0022;
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("pre_rst_valid", int'(out_valid), 1);
    #1 rst = 1'b1;
    #1 chk("rst_async_valid", int'(out_valid), 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_idle", int'(out_valid), 0);
    end
    @(posedge clk);
    #1;
    send(16'h0080);
    drain();

    // Random magnitudes with random downstream stalls
    fork
      begin
        for (int k = 0; k < 60; k++) begin
          send(16'($urandom_range(0, 65535) >> $urandom_range(0, 16)));
        end
        bp_done = 1'b1;
      end
      begin
        while (!bp_done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
